store_trace_buffer: RTL

- Downstream observer of the single-cycle MIPS core's data-memory write port.
- Sits beside the data memory on the top-level bus; taps memwrite, dataadr and writedata.
- Captures every store into a FIFO that a host or bench drains over a valid/ready handshake.
- Contains a sticky pass/fail checker: a store of PASS_DATA to PASS_ADR is the success signature; any store to an address other than IGNORE_ADR is failure.

---
 rtl/mips_dbg_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/store_trace_buffer.sv | 106 ++++++++++
 3 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared debug-observer types for the MIPS store trace path.
//   chk_state_t   : pass/fail checker states
//   trace_entry_t : one captured store {adr, data}
//   DEF_*         : default success/scratch signature constants
package mips_dbg_pkg;

    typedef enum logic [1:0] {
        CHK_RUN  = 2'd0,
        CHK_PASS = 2'd1,
        CHK_FAIL = 2'd2
    } chk_state_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
    } trace_entry_t;

    localparam int          ENTRY_W        = $bits(trace_entry_t);
    localparam logic [31:0] DEF_PASS_ADR   = 32'd84;
    localparam logic [31:0] DEF_PASS_DATA  = 32'd7;
    localparam logic [31:0] DEF_IGNORE_ADR = 32'd80;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, DEPTH (power of two) x WIDTH.
//   clk, reset    : clock, async active-low reset (clears pointers)
//   push, wdata   : write request; ignored when full unless popping this cycle
//   pop           : read request; ignored when empty
//   rdata         : head entry, zero while empty
//   full, empty   : occupancy flags
//   count         : occupancy, 0..DEPTH
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_en;
    logic             pop_en;

    // A pop in the same cycle frees the slot being written, so full+pop still accepts.
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_en)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/store_trace_buffer.sv
// Store trace buffer: observes the MIPS data-memory write port, queues every
// store for a host to drain, and flags the program pass/fail signature.
//   clk, reset            : clock, async active-low reset
//   memwrite, dataadr,
//   writedata             : tapped store port
//   out_valid, out_ready,
//   out_adr, out_data     : drain handshake and head entry
//   count                 : FIFO occupancy
//   overflow, drop_count  : sticky drop flag, saturating drop counter
//   pass, fail            : sticky checker result
//
// Checker states:
//   state    | meaning
//   CHK_RUN  | no verdict yet; stores to IGNORE_ADR keep it here
//   CHK_PASS | PASS_DATA written to PASS_ADR; held until reset
//   CHK_FAIL | any other non-scratch store seen; held until reset
module store_trace_buffer
    import mips_dbg_pkg::*;
#(
    parameter int          DEPTH      = 8,
    parameter logic [31:0] PASS_ADR   = DEF_PASS_ADR,
    parameter logic [31:0] PASS_DATA  = DEF_PASS_DATA,
    parameter logic [31:0] IGNORE_ADR = DEF_IGNORE_ADR
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     memwrite,
    input  logic [31:0]              dataadr,
    input  logic [31:0]              writedata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_adr,
    output logic [31:0]              out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    output logic                     pass,
    output logic                     fail
);

    trace_entry_t wr_entry;
    trace_entry_t rd_entry;
    logic         fifo_full;
    logic         fifo_empty;
    logic         pop;
    logic         drop;
    chk_state_t   chk_state;
    chk_state_t   chk_next;

    assign wr_entry = '{adr: dataadr, data: writedata};

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (memwrite),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_adr   = rd_entry.adr;
    assign out_data  = rd_entry.data;
    assign drop      = memwrite && fifo_full && !pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) chk_state <= CHK_RUN;
        else        chk_state <= chk_next;
    end

    // Dropped stores still count toward the verdict.
    always_comb begin
        chk_next = chk_state;
        pass     = 1'b0;
        fail     = 1'b0;
        unique case (chk_state)
            CHK_RUN: begin
                if (memwrite) begin
                    if (dataadr == PASS_ADR && writedata == PASS_DATA) chk_next = CHK_PASS;
                    else if (dataadr != IGNORE_ADR)                     chk_next = CHK_FAIL;
                end
            end
            CHK_PASS: pass = 1'b1;
            CHK_FAIL: fail = 1'b1;
            default:  chk_next = chk_state;
        endcase
    end

endmodule
